// File: rtl/n1_ifq.sv
// ============================================================================
//  Module   : n1_ifq
//  Purpose  : N1 instruction fetch queue. Issues sequential pipelined-Wishbone
//             reads and buffers the returned opcodes for the instruction register.
//  Option   : N1_IFQ_BYPASS_EN - zero-latency bypass of an ack into an empty queue
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module n1_ifq #(
    parameter int DEPTH   = 4,
    parameter int PBUS_AW = 14
) (
    input  logic                     clk_i,
    input  logic                     sync_rst_i,
    output logic                     pbus_cyc_o,
    output logic                     pbus_stb_o,
    output logic [PBUS_AW-1:0]       pbus_adr_o,
    input  logic                     pbus_stall_i,
    input  logic                     pbus_ack_i,
    input  logic [15:0]              pbus_dat_i,
    input  logic                     fc2ifq_redirect_i,
    input  logic [PBUS_AW-1:0]       pagu2ifq_adr_i,
    input  logic                     fc2ifq_halt_i,
    output logic                     ifq2ir_vld_o,
    output logic [15:0]              ifq2ir_dat_o,
    output logic [PBUS_AW-1:0]       ifq2ir_adr_o,
    input  logic                     ir2ifq_rdy_i,
    output logic [$clog2(DEPTH):0]   prb_ifq_lvl_o,
    output logic [$clog2(DEPTH):0]   prb_ifq_drop_o
);

    localparam int               c_PW        = $clog2(DEPTH);
    localparam int               c_LW        = c_PW + 1;
    localparam logic [c_LW-1:0]  c_DEPTH_LV  = c_LW'(DEPTH);
    localparam logic [c_LW:0]    c_DEPTH_EXT = (c_LW+1)'(DEPTH);

    logic                r_stb;
    logic [PBUS_AW-1:0]  r_bus_adr;
    logic [PBUS_AW-1:0]  r_req_adr;
    logic [PBUS_AW-1:0]  r_ack_adr;
    logic [c_LW-1:0]     r_out;
    logic [c_LW-1:0]     r_drop;
    logic [c_LW-1:0]     r_lvl;
    logic [c_PW-1:0]     r_wp;
    logic [c_PW-1:0]     r_rp;
    logic [15:0]         r_mem_dat [DEPTH];
    logic [PBUS_AW-1:0]  r_mem_adr [DEPTH];

    logic                w_ack;
    logic                w_stale;
    logic                w_keep;
    logic                w_empty;
    logic                w_full;
    logic                w_pop_fifo;
    logic                w_byp_take;
    logic                w_push;
    logic                w_overflow;
    logic [c_LW-1:0]     w_lvl_nxt;
    logic [c_LW-1:0]     w_out_base;
    logic [c_LW:0]       w_credit_sum;
    logic                w_issue;

    // Acks with nothing outstanding (e.g. just after reset) are ignored.
    assign w_ack      = pbus_ack_i & (r_out != '0);
    assign w_stale    = w_ack & (r_drop != '0);
    assign w_keep     = w_ack & (r_drop == '0) & ~fc2ifq_redirect_i;
    assign w_empty    = (r_lvl == '0);
    assign w_full     = (r_lvl == c_DEPTH_LV);
    assign w_pop_fifo = ~w_empty & ir2ifq_rdy_i & ~fc2ifq_redirect_i;

`ifdef N1_IFQ_BYPASS_EN
    logic w_byp;
    assign w_byp        = w_empty & w_keep;
    assign w_byp_take   = w_byp & ir2ifq_rdy_i;
    assign ifq2ir_vld_o = ~w_empty | w_byp;
    assign ifq2ir_dat_o = w_byp ? pbus_dat_i : r_mem_dat[r_rp];
    assign ifq2ir_adr_o = w_byp ? r_ack_adr  : r_mem_adr[r_rp];
`else
    assign w_byp_take   = 1'b0;
    assign ifq2ir_vld_o = ~w_empty;
    assign ifq2ir_dat_o = r_mem_dat[r_rp];
    assign ifq2ir_adr_o = r_mem_adr[r_rp];
`endif

    assign w_push     = w_keep & ~w_byp_take & (~w_full | w_pop_fifo);
    assign w_overflow = w_keep & ~w_byp_take & w_full & ~w_pop_fifo;

    assign w_lvl_nxt  = fc2ifq_redirect_i ? '0
                      : r_lvl + c_LW'(w_push) - c_LW'(w_pop_fifo);
    assign w_out_base = r_out - c_LW'(w_ack);

    // Credit is reserved at issue: queued words plus requests in flight never exceed DEPTH.
    assign w_credit_sum = {1'b0, w_lvl_nxt} + {1'b0, w_out_base};
    assign w_issue      = (~r_stb | ~pbus_stall_i) & ~fc2ifq_halt_i & ~fc2ifq_redirect_i
                        & (w_credit_sum < c_DEPTH_EXT);

    always_ff @(posedge clk_i) begin
        if (!sync_rst_i) begin
            r_stb     <= 1'b0;
            r_bus_adr <= '0;
            r_req_adr <= '0;
            r_ack_adr <= '0;
            r_out     <= '0;
            r_drop    <= '0;
            r_lvl     <= '0;
            r_wp      <= '0;
            r_rp      <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem_dat[i] <= '0;
                r_mem_adr[i] <= '0;
            end
        end else begin
            // A stalled strobe stays on the bus untouched, even across redirect or halt.
            if (!(r_stb && pbus_stall_i)) begin
                r_stb <= w_issue;
                if (w_issue) begin
                    r_bus_adr <= r_req_adr;
                end
            end
            if (fc2ifq_redirect_i) begin
                r_req_adr <= pagu2ifq_adr_i;
            end else if (w_issue) begin
                r_req_adr <= r_req_adr + 1'b1;
            end
            r_out <= w_out_base + c_LW'(w_issue);
            r_lvl <= w_lvl_nxt;

            if (fc2ifq_redirect_i) begin
                r_drop    <= w_out_base;
                r_ack_adr <= pagu2ifq_adr_i;
                r_wp      <= '0;
                r_rp      <= '0;
            end else begin
                if (w_stale) begin
                    r_drop <= r_drop - 1'b1;
                end
                if (w_keep) begin
                    r_ack_adr <= r_ack_adr + 1'b1;
                end
                if (w_push) begin
                    r_mem_dat[r_wp] <= pbus_dat_i;
                    r_mem_adr[r_wp] <= r_ack_adr;
                    r_wp            <= r_wp + 1'b1;
                end
                if (w_pop_fifo) begin
                    r_rp <= r_rp + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (sync_rst_i) begin
            a_no_overflow: assert (!w_overflow);
        end
    end

    assign pbus_stb_o     = r_stb;
    assign pbus_adr_o     = r_bus_adr;
    assign pbus_cyc_o     = r_stb | (r_out != '0);
    assign prb_ifq_lvl_o  = r_lvl;
    assign prb_ifq_drop_o = r_drop;

endmodule

`default_nettype wire

// File: tb/tb_n1_ifq.sv
// ============================================================================
//  Module   : tb_n1_ifq
//  Purpose  : Directed self-checking bench for n1_ifq with a pipelined bus slave
//             and an in-order scoreboard of expected IR words.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_n1_ifq;

    localparam int DEPTH = 4;
    localparam int AW    = 14;

    logic            clk = 1'b0;
    logic            sync_rst_i = 1'b0;
    logic            pbus_cyc_o, pbus_stb_o;
    logic [AW-1:0]   pbus_adr_o;
    logic            pbus_stall_i = 1'b0;
    logic            pbus_ack_i = 1'b0;
    logic [15:0]     pbus_dat_i = '0;
    logic            fc2ifq_redirect_i = 1'b0;
    logic [AW-1:0]   pagu2ifq_adr_i = '0;
    logic            fc2ifq_halt_i = 1'b0;
    logic            ifq2ir_vld_o;
    logic [15:0]     ifq2ir_dat_o;
    logic [AW-1:0]   ifq2ir_adr_o;
    logic            ir2ifq_rdy_i = 1'b0;
    logic [2:0]      prb_ifq_lvl_o, prb_ifq_drop_o;

    always #5 clk = ~clk;

    n1_ifq #(.DEPTH(DEPTH), .PBUS_AW(AW)) dut (
        .clk_i(clk), .sync_rst_i(sync_rst_i),
        .pbus_cyc_o(pbus_cyc_o), .pbus_stb_o(pbus_stb_o), .pbus_adr_o(pbus_adr_o),
        .pbus_stall_i(pbus_stall_i), .pbus_ack_i(pbus_ack_i), .pbus_dat_i(pbus_dat_i),
        .fc2ifq_redirect_i(fc2ifq_redirect_i), .pagu2ifq_adr_i(pagu2ifq_adr_i),
        .fc2ifq_halt_i(fc2ifq_halt_i),
        .ifq2ir_vld_o(ifq2ir_vld_o), .ifq2ir_dat_o(ifq2ir_dat_o), .ifq2ir_adr_o(ifq2ir_adr_o),
        .ir2ifq_rdy_i(ir2ifq_rdy_i),
        .prb_ifq_lvl_o(prb_ifq_lvl_o), .prb_ifq_drop_o(prb_ifq_drop_o)
    );

    int           vectors = 0;
    int           miscompares = 0;
    logic [29:0]  sb_q[$];
    logic [AW-1:0] pend_q[$];
    logic [AW-1:0] acc_log[$];
    logic [AW-1:0] pop_log[$];
    logic [AW-1:0] exp_issue_adr = '0;
    int           acc_cnt = 0;
    int           pop_cnt = 0;
    bit           hold_acks = 1'b0;
    bit           stall_on = 1'b0;

    function automatic logic [15:0] f_dat(input logic [AW-1:0] a);
        return {a[5:0], a[13:4]} ^ 16'h5A3C;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(negedge clk);
            #2;
        end
    endtask

    task automatic flow_to(input logic [AW-1:0] tgt);
        sb_q.delete();
        acc_log.delete();
        pop_log.delete();
        exp_issue_adr = tgt;
    endtask

    // Pipelined slave: accepts when stb & !stall, acks in order one cycle later.
    initial begin
        logic [AW-1:0] a;
        forever begin
            @(negedge clk);
            if (!sync_rst_i) begin
                pbus_ack_i   = 1'b0;
                pbus_stall_i = 1'b0;
            end else begin
                if (!hold_acks && pend_q.size() > 0) begin
                    a          = pend_q.pop_front();
                    pbus_ack_i = 1'b1;
                    pbus_dat_i = f_dat(a);
                end else begin
                    pbus_ack_i = 1'b0;
                    pbus_dat_i = '0;
                end
                pbus_stall_i = stall_on;
                if (pbus_stb_o && !pbus_stall_i) begin
                    pend_q.push_back(pbus_adr_o);
                    acc_log.push_back(pbus_adr_o);
                    acc_cnt++;
                    if (pbus_adr_o == exp_issue_adr) begin
                        sb_q.push_back({pbus_adr_o, f_dat(pbus_adr_o)});
                        exp_issue_adr = exp_issue_adr + 1'b1;
                    end
                end
            end
        end
    end

    // IR-side monitor: every consumed word must be the next expected one.
    initial begin
        logic [29:0] e;
        forever begin
            @(negedge clk);
            #3;
            if (sync_rst_i) begin
                check("lvl_le_depth", 32'(prb_ifq_lvl_o <= 3'd4), 32'd1);
                if (ifq2ir_vld_o && ir2ifq_rdy_i && !fc2ifq_redirect_i) begin
                    pop_cnt++;
                    pop_log.push_back(ifq2ir_adr_o);
                    check("sb_pending", 32'(sb_q.size() != 0), 32'd1);
                    if (sb_q.size() != 0) begin
                        e = sb_q.pop_front();
                        check("ir_adr", 32'(ifq2ir_adr_o), 32'(e[29:16]));
                        check("ir_dat", 32'(ifq2ir_dat_o), 32'(e[15:0]));
                    end
                end
            end
        end
    end

    task automatic do_reset();
        sync_rst_i        = 1'b0;
        fc2ifq_redirect_i = 1'b0;
        fc2ifq_halt_i     = 1'b0;
        hold_acks         = 1'b0;
        stall_on          = 1'b0;
        step(1);
        pend_q.delete();
        flow_to('0);
        acc_cnt = 0;
        pop_cnt = 0;
        step(2);
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_stb"},  32'(pbus_stb_o), 32'd0);
        check({tag, "_cyc"},  32'(pbus_cyc_o), 32'd0);
        check({tag, "_adr"},  32'(pbus_adr_o), 32'd0);
        check({tag, "_vld"},  32'(ifq2ir_vld_o), 32'd0);
        check({tag, "_dat"},  32'(ifq2ir_dat_o), 32'd0);
        check({tag, "_iadr"}, 32'(ifq2ir_adr_o), 32'd0);
        check({tag, "_lvl"},  32'(prb_ifq_lvl_o), 32'd0);
        check({tag, "_drop"}, 32'(prb_ifq_drop_o), 32'd0);
    endtask

    task automatic go_quiet();
        fc2ifq_halt_i = 1'b1;
        step(10);
        check("quiet_cyc", 32'(pbus_cyc_o), 32'd0);
        check("quiet_lvl", 32'(prb_ifq_lvl_o), 32'd0);
    endtask

    initial begin
        logic [AW-1:0] xa;
        logic [AW-1:0] ca;

        // Reset state, then free run with rdy=1
        ir2ifq_rdy_i = 1'b1;
        do_reset();
        check_reset_state("rst0");
        sync_rst_i = 1'b1;
        step(1);
        check("first_stb", 32'(pbus_stb_o), 32'd1);
        check("first_adr", 32'(pbus_adr_o), 32'd0);
        step(1);
        check("second_adr", 32'(pbus_adr_o), 32'd1);
        step(30);
        check("freerun_pops", 32'(pop_cnt >= 20), 32'd1);

        // Mid-operation reset, then rdy=0 back-pressure
        ir2ifq_rdy_i = 1'b0;
        do_reset();
        check_reset_state("rst1");
        sync_rst_i = 1'b1;
        step(10);
        check("bp_accepts", 32'(acc_cnt), 32'd4);
        check("bp_stb", 32'(pbus_stb_o), 32'd0);
        check("bp_lvl", 32'(prb_ifq_lvl_o), 32'd4);
        ir2ifq_rdy_i = 1'b1;
        step(1);
        ir2ifq_rdy_i = 1'b0;
        step(6);
        check("bp_one_more", 32'(acc_cnt), 32'd5);
        check("bp_lvl_refill", 32'(prb_ifq_lvl_o), 32'd4);
        check("bp_stb_low", 32'(pbus_stb_o), 32'd0);
        ir2ifq_rdy_i = 1'b1;

        // Single word from an empty queue: ack-to-vld latency
        go_quiet();
        xa = exp_issue_adr;
        fc2ifq_halt_i = 1'b0;
        step(1);
        fc2ifq_halt_i = 1'b1;
        step(1);
        check("lat_ack", 32'(pbus_ack_i), 32'd1);
`ifdef N1_IFQ_BYPASS_EN
        check("byp_vld", 32'(ifq2ir_vld_o), 32'd1);
        check("byp_adr", 32'(ifq2ir_adr_o), 32'(xa));
        check("byp_lvl", 32'(prb_ifq_lvl_o), 32'd0);
        step(1);
        check("byp_lvl_after", 32'(prb_ifq_lvl_o), 32'd0);
        check("byp_vld_after", 32'(ifq2ir_vld_o), 32'd0);
`else
        check("lat_vld_same", 32'(ifq2ir_vld_o), 32'd0);
        step(1);
        check("lat_vld_next", 32'(ifq2ir_vld_o), 32'd1);
        check("lat_adr_next", 32'(ifq2ir_adr_o), 32'(xa));
        check("lat_lvl_next", 32'(prb_ifq_lvl_o), 32'd1);
        step(1);
        check("lat_lvl_drain", 32'(prb_ifq_lvl_o), 32'd0);
`endif

        // Two requests outstanding, redirect in the same cycle as one ack
        go_quiet();
        hold_acks = 1'b1;
        fc2ifq_halt_i = 1'b0;
        for (int i = 0; i < 10 && pend_q.size() < 2; i++) step(1);
        fc2ifq_halt_i = 1'b1;
        check("rd_two_pending", 32'(pend_q.size()), 32'd2);
        step(1);
        check("rd_stb_low", 32'(pbus_stb_o), 32'd0);
        hold_acks = 1'b0;
        for (int i = 0; i < 5 && !pbus_ack_i; i++) step(1);
        check("rd_ack_seen", 32'(pbus_ack_i), 32'd1);
        fc2ifq_redirect_i = 1'b1;
        pagu2ifq_adr_i    = 14'h0100;
        fc2ifq_halt_i     = 1'b0;
        flow_to(14'h0100);
        step(1);
        fc2ifq_redirect_i = 1'b0;
        check("rd_drop", 32'(prb_ifq_drop_o), 32'd1);
        check("rd_stb_gap", 32'(pbus_stb_o), 32'd0);
        check("rd_vld", 32'(ifq2ir_vld_o), 32'd0);
        step(1);
        check("rd_drop_done", 32'(prb_ifq_drop_o), 32'd0);
        check("rd_new_stb", 32'(pbus_stb_o), 32'd1);
        check("rd_new_adr", 32'(pbus_adr_o), 32'h0100);
        for (int i = 0; i < 10 && pop_log.size() < 1; i++) step(1);
        check("rd_popped", 32'(pop_log.size() >= 1), 32'd1);
        if (pop_log.size() >= 1) check("rd_first_ir_adr", 32'(pop_log[0]), 32'h0100);

        // Redirect while a strobe is stalled for three cycles
        go_quiet();
        stall_on = 1'b1;
        ca = exp_issue_adr;
        fc2ifq_halt_i = 1'b0;
        step(1);
        check("st_stb", 32'(pbus_stb_o), 32'd1);
        check("st_adr", 32'(pbus_adr_o), 32'(ca));
        step(1);
        fc2ifq_redirect_i = 1'b1;
        pagu2ifq_adr_i    = 14'h2000;
        flow_to(14'h2000);
        step(1);
        fc2ifq_redirect_i = 1'b0;
        check("st_hold_stb", 32'(pbus_stb_o), 32'd1);
        check("st_hold_adr", 32'(pbus_adr_o), 32'(ca));
        check("st_drop", 32'(prb_ifq_drop_o), 32'd1);
        stall_on = 1'b0;
        step(1);
        check("st_hold_adr2", 32'(pbus_adr_o), 32'(ca));
        step(1);
        check("st_resume_stb", 32'(pbus_stb_o), 32'd1);
        check("st_resume_adr", 32'(pbus_adr_o), 32'h2000);
        step(1);
        check("st_drop_done", 32'(prb_ifq_drop_o), 32'd0);
        for (int i = 0; i < 10 && pop_log.size() < 1; i++) step(1);
        check("st_popped", 32'(pop_log.size() >= 1), 32'd1);
        if (pop_log.size() >= 1) check("st_first_ir_adr", 32'(pop_log[0]), 32'h2000);

        // Address wrap at the top of the program space
        go_quiet();
        fc2ifq_redirect_i = 1'b1;
        pagu2ifq_adr_i    = 14'h3FFE;
        fc2ifq_halt_i     = 1'b0;
        flow_to(14'h3FFE);
        step(1);
        fc2ifq_redirect_i = 1'b0;
        for (int i = 0; i < 20 && pop_log.size() < 3; i++) step(1);
        check("wr_popped", 32'(pop_log.size() >= 3 && acc_log.size() >= 3), 32'd1);
        if (pop_log.size() >= 3 && acc_log.size() >= 3) begin
            check("wr_stb0", 32'(acc_log[0]), 32'h3FFE);
            check("wr_stb1", 32'(acc_log[1]), 32'h3FFF);
            check("wr_stb2", 32'(acc_log[2]), 32'h0000);
            check("wr_ir0",  32'(pop_log[0]), 32'h3FFE);
            check("wr_ir1",  32'(pop_log[1]), 32'h3FFF);
            check("wr_ir2",  32'(pop_log[2]), 32'h0000);
        end
        step(5);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire
